// File: rtl/wavepool_mux_pkg.sv
// Shared constants for the wavepool slot selectors and arbiters.
package wavepool_mux_pkg;

  localparam logic MUX_MODE_EXPLICIT = 1'b0;
  localparam logic MUX_MODE_RR       = 1'b1;

  localparam int MUX_NUM_IN_DEFAULT = 8;
  localparam int MUX_WIDTH_DEFAULT  = 64;

endpackage

// File: rtl/wavepool_rr_pick.sv
// Combinational rotating-priority finder: first set bit of mask at or above ptr,
// wrapping at NUM_IN. Shared by the wavepool arbiters.
module wavepool_rr_pick #(
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] mask,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  logic [SEL_W-1:0]  base_s;
  logic [SEL_W-1:0]  off_s;
  logic [NUM_IN-1:0] rot_s;
  logic [NUM_IN-1:0] scan_s;
  logic [SEL_W:0]    sum_s;
  logic              found_s;

  // rotate the mask so that bit 0 is the slot at ptr; an out-of-range ptr restarts at 0
  always_comb begin
    base_s = ({1'b0, ptr} < (SEL_W+1)'(NUM_IN)) ? ptr : '0;
    rot_s  = NUM_IN'({mask, mask} >> base_s);
  end

  // lowest set bit of the rotated mask gives the distance from ptr
  always_comb begin
    scan_s  = rot_s;
    found_s = 1'b0;
    off_s   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      off_s   = (!found_s && scan_s[0]) ? SEL_W'(k) : off_s;
      found_s = found_s | scan_s[0];
      scan_s  = scan_s >> 1;
    end
  end

  // undo the rotation modulo NUM_IN
  always_comb begin
    sum_s = {1'b0, base_s} + {1'b0, off_s};
    if (sum_s >= (SEL_W+1)'(NUM_IN)) begin
      sum_s = sum_s - (SEL_W+1)'(NUM_IN);
    end else begin
      sum_s = sum_s;
    end
    grant_idx = sum_s[SEL_W-1:0];
    any       = |mask;
  end

endmodule

// File: rtl/wavepool_sel_mux_rr.sv
// Registered N-to-1 slot selector (explicit index or round-robin) with a
// valid/ready output stage backed by a one-entry skid buffer.
module wavepool_sel_mux_rr
  import wavepool_mux_pkg::*;
#(
  parameter  int NUM_IN = MUX_NUM_IN_DEFAULT,
  parameter  int WIDTH  = MUX_WIDTH_DEFAULT,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_mode,
  input  logic [SEL_W-1:0]        req_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_slot,
  output logic                    out_err
);

  localparam int EW = 1 + SEL_W + WIDTH;

  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W-1:0] rr_ptr_nxt_s;
  logic [SEL_W-1:0] grant_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             any_s;
  logic [WIDTH-1:0] pick_data_s;
  logic             pick_vld_s;
  logic             sel_in_range_s;

  logic [WIDTH-1:0] res_data_s;
  logic [SEL_W-1:0] res_slot_s;
  logic             res_err_s;
  logic [EW-1:0]    res_s;

  logic             accept_s;
  logic             pop_s;
  logic [EW-1:0]    main_r, main_nxt_s;
  logic [EW-1:0]    skid_r, skid_nxt_s;
  logic             main_vld_r, main_vld_nxt_s;
  logic             skid_vld_r, skid_vld_nxt_s;
  logic             req_ready_r;

  wavepool_rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_rr_pick (
    .mask      (in_valid),
    .ptr       (rr_ptr_r),
    .grant_idx (grant_s),
    .any       (any_s)
  );

  assign accept_s = req_valid && req_ready_r;
  assign pop_s    = main_vld_r && out_ready;

  // fetch data and valid bit of the chosen slot; an out-of-range index matches nothing
  always_comb begin
    pick_idx_s     = (req_mode == MUX_MODE_RR) ? grant_s : req_sel;
    sel_in_range_s = ({1'b0, req_sel} < (SEL_W+1)'(NUM_IN));
    pick_data_s    = '0;
    pick_vld_s     = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      pick_data_s = (pick_idx_s == SEL_W'(i)) ? in_data[WIDTH*i +: WIDTH] : pick_data_s;
      pick_vld_s  = (pick_idx_s == SEL_W'(i)) ? in_valid[i] : pick_vld_s;
    end
  end

  // result formation and error reporting for both modes
  always_comb begin
    if (req_mode == MUX_MODE_RR) begin
      if (any_s) begin
        res_err_s  = 1'b0;
        res_slot_s = grant_s;
        res_data_s = pick_data_s;
      end else begin
        res_err_s  = 1'b1;
        res_slot_s = '0;
        res_data_s = '0;
      end
    end else begin
      if (sel_in_range_s && pick_vld_s) begin
        res_err_s  = 1'b0;
        res_slot_s = req_sel;
        res_data_s = pick_data_s;
      end else begin
        res_err_s  = 1'b1;
        res_slot_s = req_sel;
        res_data_s = '0;
      end
    end
    res_s = {res_err_s, res_slot_s, res_data_s};
  end

  // pointer advances past the granted slot, wrapping at NUM_IN rather than 2^SEL_W
  always_comb begin
    if (grant_s == SEL_W'(NUM_IN - 1)) begin
      rr_ptr_nxt_s = '0;
    end else begin
      rr_ptr_nxt_s = grant_s + SEL_W'(1);
    end
  end

  // round-robin pointer register, moved only by successful RR grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (accept_s && (req_mode == MUX_MODE_RR) && any_s) begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // main/skid next state; accept and skid-refill are exclusive because req_ready mirrors !skid_vld
  always_comb begin
    main_nxt_s     = main_r;
    main_vld_nxt_s = main_vld_r;
    skid_nxt_s     = skid_r;
    skid_vld_nxt_s = skid_vld_r;
    if (pop_s && skid_vld_r) begin
      main_nxt_s     = skid_r;
      main_vld_nxt_s = 1'b1;
      skid_vld_nxt_s = 1'b0;
    end else if (accept_s) begin
      if (!main_vld_r || pop_s) begin
        main_nxt_s     = res_s;
        main_vld_nxt_s = 1'b1;
      end else begin
        skid_nxt_s     = res_s;
        skid_vld_nxt_s = 1'b1;
      end
    end else if (pop_s) begin
      main_vld_nxt_s = 1'b0;
    end else begin
      main_vld_nxt_s = main_vld_r;
    end
  end

  // output buffer registers; reset discards any held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r      <= '0;
      main_vld_r  <= 1'b0;
      skid_r      <= '0;
      skid_vld_r  <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      main_r      <= main_nxt_s;
      main_vld_r  <= main_vld_nxt_s;
      skid_r      <= skid_nxt_s;
      skid_vld_r  <= skid_vld_nxt_s;
      req_ready_r <= !skid_vld_nxt_s;
    end
  end

  assign req_ready = req_ready_r;
  assign out_valid = main_vld_r;
  assign {out_err, out_slot, out_data} = main_r;

endmodule

// File: tb/tb_wavepool_sel_mux_rr.sv
// Scoreboard bench for wavepool_sel_mux_rr across three parameterisations.
module tb_wavepool_sel_mux_rr;
  import wavepool_mux_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  slot;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] bus;
  logic [7:0]   vmask;
  logic         req_valid, req_mode, out_ready;
  logic [2:0]   req_sel;
  int           cur;

  logic rv8, rdy8, ov8, oe8; logic [63:0] od8; logic [2:0] os8;
  logic rv6, rdy6, ov6, oe6; logic [63:0] od6; logic [2:0] os6;
  logic rv3, rdy3, ov3, oe3; logic [15:0] od3; logic [1:0] os3;

  logic        mon_valid, mon_rdy, mon_err;
  logic [63:0] mon_data;
  logic [2:0]  mon_slot;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   pops = 0;
  int   stalls = 0;

  always #5 clk = ~clk;

  assign rv8 = req_valid && (cur == 0);
  assign rv6 = req_valid && (cur == 1);
  assign rv3 = req_valid && (cur == 2);

  wavepool_sel_mux_rr #(.NUM_IN(8), .WIDTH(64)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(bus[511:0]), .in_valid(vmask),
    .req_valid(rv8), .req_ready(rdy8), .req_mode(req_mode), .req_sel(req_sel),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_slot(os8), .out_err(oe8));

  wavepool_sel_mux_rr #(.NUM_IN(6), .WIDTH(64)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(bus[383:0]), .in_valid(vmask[5:0]),
    .req_valid(rv6), .req_ready(rdy6), .req_mode(req_mode), .req_sel(req_sel),
    .out_valid(ov6), .out_ready(out_ready), .out_data(od6), .out_slot(os6), .out_err(oe6));

  wavepool_sel_mux_rr #(.NUM_IN(3), .WIDTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(bus[47:0]), .in_valid(vmask[2:0]),
    .req_valid(rv3), .req_ready(rdy3), .req_mode(req_mode), .req_sel(req_sel[1:0]),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_slot(os3), .out_err(oe3));

  always_comb begin
    case (cur)
      1: begin
        mon_valid = ov6; mon_rdy = rdy6; mon_err = oe6; mon_data = od6; mon_slot = os6;
      end
      2: begin
        mon_valid = ov3; mon_rdy = rdy3; mon_err = oe3;
        mon_data = {48'd0, od3}; mon_slot = {1'b0, os3};
      end
      default: begin
        mon_valid = ov8; mon_rdy = rdy8; mon_err = oe8; mon_data = od8; mon_slot = os8;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] val8(input int i);
    logic [63:0] k;
    k = 64'(i);
    return 64'h1111_0000_0000_0000 * k + k;
  endfunction

  function automatic logic [63:0] val6(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  // monitor: every handshake on the output pops and checks one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_valid && out_ready) begin
      pops++;
      if (q.size() == 0) begin
        chk("unexpected_out", {63'd0, mon_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", mon_data, e.data);
        chk("out_slot", {61'd0, mon_slot}, {61'd0, e.slot});
        chk("out_err", {63'd0, mon_err}, {63'd0, e.err});
      end
    end
  end

  task automatic send(input logic mode, input logic [2:0] sel, input logic [7:0] mask,
                      input logic [63:0] edata, input logic [2:0] eslot, input logic eerr);
    int   n;
    exp_t e;
    req_mode  = mode;
    req_sel   = sel;
    vmask     = mask;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mon_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n > 0) stalls++;
    if (!mon_rdy) begin
      chk("req_ready_timeout", {63'd0, mon_rdy}, 64'd1);
    end else begin
      e.data = edata; e.slot = eslot; e.err = eerr;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, s0;
    int seq6[6] = '{1, 2, 5, 7, 1, 2};
    int seq3[4] = '{0, 1, 2, 0};
    req_valid = 1'b0; req_mode = MUX_MODE_EXPLICIT; req_sel = 3'd0;
    vmask = 8'h00; bus = '0; out_ready = 1'b1; cur = 0;

    #12;
    chk("rst_valid", {63'd0, mon_valid}, 64'd0);
    chk("rst_ready", {63'd0, mon_rdy}, 64'd1);
    chk("rst_data", mon_data, 64'd0);
    chk("rst_slot", {61'd0, mon_slot}, 64'd0);
    chk("rst_err", {63'd0, mon_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // explicit back-to-back, NUM_IN=8
    for (int i = 0; i < 8; i++) bus[64*i +: 64] = val8(i);
    p0 = pops; s0 = stalls;
    send(MUX_MODE_EXPLICIT, 3'd5, 8'hFF, val8(5), 3'd5, 1'b0);
    chk("t1_latency", {63'd0, mon_valid}, 64'd1);
    for (int i = 0; i < 5; i++) send(MUX_MODE_EXPLICIT, 3'd5, 8'hFF, val8(5), 3'd5, 1'b0);
    idle();
    drain();
    chk("t1_pops", 64'(pops - p0), 64'd6);
    chk("t1_stalls", 64'(stalls - s0), 64'd0);

    // round-robin sequence, empty mask, mixed modes
    for (int i = 0; i < 6; i++) send(MUX_MODE_RR, 3'd0, 8'hA6, val8(seq6[i]), 3'(seq6[i]), 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'h00, 64'd0, 3'd0, 1'b1);
    send(MUX_MODE_RR, 3'd0, 8'hA6, val8(5), 3'd5, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd1, 8'hA6, val8(1), 3'd1, 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'hA6, val8(7), 3'd7, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd2, 8'hA6, val8(2), 3'd2, 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'hA6, val8(1), 3'd1, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd0, 8'hA6, 64'd0, 3'd0, 1'b1);
    send(MUX_MODE_RR, 3'd0, 8'hA6, val8(2), 3'd2, 1'b0);
    idle();
    drain();

    // errors and wrap with NUM_IN=6
    cur = 1;
    bus = '0;
    for (int i = 0; i < 6; i++) bus[64*i +: 64] = val6(i);
    send(MUX_MODE_EXPLICIT, 3'd7, 8'h3F, 64'd0, 3'd7, 1'b1);
    send(MUX_MODE_EXPLICIT, 3'd6, 8'h3F, 64'd0, 3'd6, 1'b1);
    send(MUX_MODE_EXPLICIT, 3'd3, 8'h01, 64'd0, 3'd3, 1'b1);
    send(MUX_MODE_EXPLICIT, 3'd0, 8'h01, val6(0), 3'd0, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd5, 8'h3F, val6(5), 3'd5, 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'h21, val6(0), 3'd0, 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'h21, val6(5), 3'd5, 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'h21, val6(0), 3'd0, 1'b0);
    idle();
    drain();

    // backpressure: A in main, B in skid, C waits
    cur = 0;
    for (int i = 0; i < 8; i++) bus[64*i +: 64] = val8(i);
    out_ready = 1'b0;
    p0 = pops;
    send(MUX_MODE_EXPLICIT, 3'd1, 8'hFF, val8(1), 3'd1, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd2, 8'hFF, val8(2), 3'd2, 1'b0);
    req_sel = 3'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_ready_low", {63'd0, mon_rdy}, 64'd0);
      chk("bp_hold_valid", {63'd0, mon_valid}, 64'd1);
      chk("bp_hold_slot", {61'd0, mon_slot}, 64'd1);
      chk("bp_hold_data", mon_data, val8(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_at_pop", {63'd0, mon_rdy}, 64'd0);
    @(negedge clk);
    chk("bp_ready_back", {63'd0, mon_rdy}, 64'd1);
    q.push_back('{data: val8(3), slot: 3'd3, err: 1'b0});
    @(posedge clk); #1;
    idle();
    drain();
    chk("bp_pops", 64'(pops - p0), 64'd3);

    // reset with main and skid both full
    out_ready = 1'b0;
    send(MUX_MODE_EXPLICIT, 3'd4, 8'hFF, val8(4), 3'd4, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd6, 8'hFF, val8(6), 3'd6, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, mon_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, mon_rdy}, 64'd1);
    chk("mid_rst_data", mon_data, 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    s0 = stalls;
    send(MUX_MODE_RR, 3'd0, 8'hFF, val8(0), 3'd0, 1'b0);
    chk("post_rst_no_stall", 64'(stalls - s0), 64'd0);
    idle();
    drain();

    // NUM_IN=3, WIDTH=16 wrap
    cur = 2;
    bus = '0;
    for (int i = 0; i < 3; i++) bus[16*i +: 16] = 16'hA000 + 16'(i);
    for (int i = 0; i < 4; i++)
      send(MUX_MODE_RR, 3'd0, 8'h07, {48'd0, 16'hA000 + 16'(seq3[i])}, 3'(seq3[i]), 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'h05, {48'd0, 16'hA002}, 3'd2, 1'b0);
    send(MUX_MODE_RR, 3'd0, 8'h05, {48'd0, 16'hA000}, 3'd0, 1'b0);
    send(MUX_MODE_EXPLICIT, 3'd3, 8'h07, 64'd0, 3'd3, 1'b1);
    send(MUX_MODE_RR, 3'd0, 8'h07, {48'd0, 16'hA001}, 3'd1, 1'b0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wavepool_sel_mux_rr.md
# wavepool_sel_mux_rr

Parametrised, registered N-to-1 slot selector for the wavepool: it picks one WIDTH-bit slot out of NUM_IN packed slots, either by explicit index or by round-robin over a per-slot valid mask. The selection is returned through a valid/ready output stage with a one-entry skid buffer, giving full throughput under backpressure. It generalises the fixed 8x64b combinational slot mux used for wavefront-field selection to arbitrary widths and depths, adds error reporting and adds arbitration.

## Interface
- NUM_IN, default 8, number of input slots (>=2, need not be a power of 2)
- WIDTH, default 64, bits per slot
- SEL_W, localparam = $clog2(NUM_IN), slot index width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NUM_IN*WIDTH  packed slots; slot i = in_data[WIDTH*i +: WIDTH]
- in_valid  in  NUM_IN  per-slot valid mask
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted (registered)
- req_mode  in  1  0 = explicit select, 1 = round-robin
- req_sel  in  SEL_W  slot index, explicit mode only
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  selected slot data
- out_slot  out  SEL_W  selected slot index
- out_err  out  1  request could not select a valid slot

## Operation
- Request accepted on a rising edge when req_valid && req_ready. in_data, in_valid, req_mode and req_sel are sampled only at acceptance.
- Explicit mode: slot = req_sel. out_err=1 if req_sel >= NUM_IN or in_valid[req_sel]==0. On error, out_data=0; out_slot=req_sel truncated to SEL_W. rr_ptr is unchanged.
- Round-robin mode: slot = first set bit of in_valid, searching upward from rr_ptr and wrapping past NUM_IN-1 to 0. After the grant, rr_ptr <= (slot+1) mod NUM_IN, wrapping at NUM_IN, not 2^SEL_W.
- If in_valid==0 in round-robin mode: out_err=1, out_slot=0, out_data=0, rr_ptr unchanged.
- Output buffer has two entries: main and skid.
  - Main drives out_*. out_valid = main occupied.
  - Accept with main empty, or main popped (out_valid && out_ready) in the same cycle with skid empty -> main loads the new result.
  - Accept with main held (out_ready=0) and skid empty -> skid loads; req_ready=0 from the next cycle.
  - Pop with skid full -> main <= skid, skid empties; req_ready=1 from the next cycle.
  - No accept is possible while the skid is full, so no third entry exists.
- Ordering is strict FIFO. Results are never dropped or duplicated.

## Timing
- Latency 1: a request accepted at edge k appears on out_* after edge k. Results are never combinational from req_*.
- Throughput: 1 result per cycle while out_ready=1.
- req_ready = !skid_full, registered. No combinational path from out_ready to req_ready.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_slot=0, out_err=0
  - req_ready=1, rr_ptr=0, skid empty
- Reset mid-operation discards main and skid contents. The first request after release is accepted in the first cycle with rst_n=1.
- out_data, out_slot and out_err hold stable while out_valid && !out_ready.

## Structure
- Shared package wavepool_mux_pkg:
  - MUX_MODE_EXPLICIT=1'b0, MUX_MODE_RR=1'b1
  - default NUM_IN and WIDTH constants
- One sub-module: wavepool_rr_pick. It is a combinational rotating-priority finder. Inputs are mask[NUM_IN] and ptr[SEL_W]; outputs are grant_idx[SEL_W] and any. It is reused by other wavepool arbiters.
- Top-level holds the mode mux, error logic, rr_ptr register and the main/skid buffer.

## Test plan
- Explicit, NUM_IN=8, WIDTH=64: slot i = 64'h1111_0000_0000_0000*i + i, in_valid=8'hFF, req_sel=5 back-to-back with out_ready=1 -> one result per cycle, out_data=slot 5 value, out_slot=5, out_err=0, latency 1.
- Round-robin: in_valid=8'b1010_0110, 6 consecutive requests -> out_slot sequence 1,2,5,7,1,2. Then in_valid=0 -> out_err=1, out_slot=0, out_data=0, and the next grant is still slot 5.
- Errors with NUM_IN=6: req_sel=7 -> out_err=1, out_data=0. Then in_valid=6'b000001 with req_sel=3 -> out_err=1.
  - Mixed modes: explicit requests between RR requests leave the RR sequence unaffected.
- Backpressure: out_ready=0 with requests A,B,C offered each cycle:
  - A is held in main, B is in skid, req_ready=0, C waits.
  - out_ready=1 -> A, B, C are delivered in order, with no loss or duplication.
  - req_ready returns to 1 the cycle after A pops.
- Reset mid-operation: assert rst_n=0 with main and skid full -> out_valid=0 and req_ready=1 immediately. After release, an RR request with in_valid=8'hFF grants slot 0.
- Wrap/width: NUM_IN=3, WIDTH=16, RR with in_valid=3'b111 -> out_slot sequence 0,1,2,0, with rr_ptr never reaching 3.
